// File: rtl/vcve2_dmem_pkg.sv
// Shared types and widths for the data-memory arbiter slice.
package vcve2_dmem_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  localparam int unsigned DMEM_AW = 32;
  localparam int unsigned DMEM_DW = 32;

endpackage

// File: rtl/vcve2_dmem_id_fifo.sv
// In-flight requester ID FIFO; the head tells the arbiter where the next response belongs.
module vcve2_dmem_id_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 1,
  localparam int unsigned CntW = $clog2(Depth + 1),
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wrPtr;
  logic [PtrW-1:0]  r_rdPtr;
  logic [CntW-1:0]  r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign full_o   = (r_count == CntW'(Depth));
  assign empty_o  = (r_count == '0);
  assign count_o  = r_count;
  assign head_o   = r_mem[r_rdPtr];
  assign w_doPush = push_i && !full_o;
  assign w_doPop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (w_doPush) r_mem[r_wrPtr] <= data_i;
  end

  // Pointers wrap explicitly so non-power-of-two depths stay in range.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= (r_wrPtr == PtrW'(Depth - 1)) ? '0 : r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= (r_rdPtr == PtrW'(Depth - 1)) ? '0 : r_rdPtr + 1'b1;
      if (w_doPush && !w_doPop)      r_count <= r_count + 1'b1;
      else if (!w_doPush && w_doPop) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/vcve2_dmem_nport_arbiter.sv
// N-requester arbiter onto one OBI-style data port, with a held selection until granted
// and in-order response routing through an ID FIFO.
module vcve2_dmem_nport_arbiter
  import vcve2_dmem_pkg::*;
#(
  parameter int unsigned NumPorts       = 2,
  parameter int unsigned MaxOutstanding = 2,
  parameter arb_mode_e   ArbMode        = ARB_RR,
  localparam int unsigned IdW  = (NumPorts > 1) ? $clog2(NumPorts) : 1,
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NumPorts-1:0]               req_i,
  output logic [NumPorts-1:0]               gnt_o,
  output logic [NumPorts-1:0]               rvalid_o,
  output logic [NumPorts-1:0]               err_o,
  input  logic [NumPorts-1:0]               we_i,
  input  logic [NumPorts-1:0][3:0]          be_i,
  input  logic [NumPorts-1:0][DMEM_AW-1:0]  addr_i,
  input  logic [NumPorts-1:0][DMEM_DW-1:0]  wdata_i,
  output logic [DMEM_DW-1:0]                rdata_o,
  output logic                              data_req_o,
  output logic                              data_we_o,
  output logic [3:0]                        data_be_o,
  output logic [DMEM_AW-1:0]                data_addr_o,
  output logic [DMEM_DW-1:0]                data_wdata_o,
  input  logic                              data_gnt_i,
  input  logic                              data_rvalid_i,
  input  logic                              data_err_i,
  input  logic [DMEM_DW-1:0]                data_rdata_i,
  output logic [CntW-1:0]                   outstanding_o,
  output logic                              unexpected_rsp_o
);

  logic [IdW-1:0] r_rrPtr;
  logic           r_lock;
  logic [IdW-1:0] r_lockId;
  logic [IdW-1:0] w_winner;
  logic [IdW-1:0] w_idx;
  logic           w_found;
  logic [IdW-1:0] w_head;
  logic           w_fifoFull;
  logic           w_fifoEmpty;
  logic           w_push;
  logic           w_pop;

  // A stalled request keeps its port selected so the address stays stable until granted.
  always_comb begin
    w_winner = '0;
    w_idx    = '0;
    w_found  = 1'b0;
    if (r_lock) begin
      w_winner = r_lockId;
    end else if (ArbMode == ARB_FIXED) begin
      for (int i = NumPorts - 1; i >= 0; i--) begin
        if (req_i[i]) w_winner = IdW'(i);
      end
    end else begin
      for (int i = 0; i < NumPorts; i++) begin
        w_idx = IdW'((int'(r_rrPtr) + i) % NumPorts);
        if (!w_found && req_i[w_idx]) begin
          w_winner = w_idx;
          w_found  = 1'b1;
        end
      end
    end
  end

  assign data_req_o   = req_i[w_winner] && !w_fifoFull;
  assign data_we_o    = we_i[w_winner];
  assign data_be_o    = be_i[w_winner];
  assign data_addr_o  = addr_i[w_winner];
  assign data_wdata_o = wdata_i[w_winner];
  assign rdata_o      = data_rdata_i;

  assign w_push           = data_req_o && data_gnt_i;
  assign w_pop            = data_rvalid_i && !w_fifoEmpty;
  assign unexpected_rsp_o = data_rvalid_i && w_fifoEmpty;

  always_comb begin
    gnt_o    = '0;
    rvalid_o = '0;
    err_o    = '0;
    if (w_push) gnt_o[w_winner] = 1'b1;
    if (w_pop) begin
      rvalid_o[w_head] = 1'b1;
      err_o[w_head]    = data_err_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rrPtr  <= '0;
      r_lock   <= 1'b0;
      r_lockId <= '0;
    end else begin
      r_lock <= data_req_o && !data_gnt_i;
      if (data_req_o && !data_gnt_i) r_lockId <= w_winner;
      if (ArbMode == ARB_RR && w_push)
        r_rrPtr <= (w_winner == IdW'(NumPorts - 1)) ? '0 : w_winner + 1'b1;
    end
  end

  vcve2_dmem_id_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdW)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  (w_winner),
    .head_o  (w_head),
    .full_o  (w_fifoFull),
    .empty_o (w_fifoEmpty),
    .count_o (outstanding_o)
  );

endmodule

// File: tb/tb_vcve2_dmem_nport_arbiter.sv
// Directed bench: a 2-port fixed-priority instance and a 4-port round-robin instance.
module tb_vcve2_dmem_nport_arbiter;
  import vcve2_dmem_pkg::*;

  logic clk;
  logic rstN;
  int   errCount;
  int   checkCount;

  logic [1:0]       aReq, aGntO, aRvalidO, aErrO, aWe;
  logic [1:0][3:0]  aBe;
  logic [1:0][31:0] aAddr, aWdata;
  logic [31:0]      aRdataO, aAddrO, aWdataO;
  logic             aDataReq, aDataWe, aGnt, aRvalid, aErr, aUnexp;
  logic [3:0]       aBeO;
  logic [1:0]       aOutst;

  logic [3:0]       bReq, bGntO, bRvalidO, bErrO, bWe;
  logic [3:0][3:0]  bBe;
  logic [3:0][31:0] bAddr, bWdata;
  logic [31:0]      bRdataO, bAddrO, bWdataO, bRdata;
  logic             bDataReq, bDataWe, bGnt, bRvalid, bErr, bUnexp;
  logic [3:0]       bBeO;
  logic [1:0]       bOutst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vcve2_dmem_nport_arbiter #(
    .NumPorts(2), .MaxOutstanding(2), .ArbMode(ARB_FIXED)
  ) dutFixed (
    .clk_i(clk), .rst_ni(rstN), .req_i(aReq), .gnt_o(aGntO), .rvalid_o(aRvalidO),
    .err_o(aErrO), .we_i(aWe), .be_i(aBe), .addr_i(aAddr), .wdata_i(aWdata),
    .rdata_o(aRdataO), .data_req_o(aDataReq), .data_we_o(aDataWe), .data_be_o(aBeO),
    .data_addr_o(aAddrO), .data_wdata_o(aWdataO), .data_gnt_i(aGnt),
    .data_rvalid_i(aRvalid), .data_err_i(aErr), .data_rdata_i(32'h0),
    .outstanding_o(aOutst), .unexpected_rsp_o(aUnexp)
  );

  vcve2_dmem_nport_arbiter #(
    .NumPorts(4), .MaxOutstanding(2), .ArbMode(ARB_RR)
  ) dutRr (
    .clk_i(clk), .rst_ni(rstN), .req_i(bReq), .gnt_o(bGntO), .rvalid_o(bRvalidO),
    .err_o(bErrO), .we_i(bWe), .be_i(bBe), .addr_i(bAddr), .wdata_i(bWdata),
    .rdata_o(bRdataO), .data_req_o(bDataReq), .data_we_o(bDataWe), .data_be_o(bBeO),
    .data_addr_o(bAddrO), .data_wdata_o(bWdataO), .data_gnt_i(bGnt),
    .data_rvalid_i(bRvalid), .data_err_i(bErr), .data_rdata_i(bRdata),
    .outstanding_o(bOutst), .unexpected_rsp_o(bUnexp)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives one instance's handshake for a cycle and parks the other one idle.
  task automatic applyStimulus(input bit useB, input logic [3:0] req, input logic gnt,
                               input logic rvalid, input logic err);
    @(negedge clk);
    aReq = '0; aGnt = 1'b0; aRvalid = 1'b0; aErr = 1'b0;
    bReq = '0; bGnt = 1'b0; bRvalid = 1'b0; bErr = 1'b0;
    if (useB) begin
      bReq = req; bGnt = gnt; bRvalid = rvalid; bErr = err;
    end else begin
      aReq = req[1:0]; aGnt = gnt; aRvalid = rvalid; aErr = err;
    end
    #1;
  endtask

  logic [3:0] rrGnt [5];
  logic [3:0] rrRv  [5];

  initial begin
    errCount = 0; checkCount = 0;
    rstN = 1'b0;
    aReq = '0; aGnt = 0; aRvalid = 0; aErr = 0; aWe = 2'b10;
    aBe = {4'b1111, 4'b1111}; aAddr = {32'hA000_0004, 32'hA000_0000}; aWdata = '0;
    bReq = '0; bGnt = 0; bRvalid = 0; bErr = 0; bWe = 4'b0100; bRdata = 32'hDEAD_BEEF;
    bBe = {4'b1111, 4'b0011, 4'b1111, 4'b1111};
    bAddr = {32'h1000_0300, 32'h1000_0200, 32'h1000_0100, 32'h1000_0000};
    bWdata = {32'h0, 32'hCAFE_0002, 32'h0, 32'h0};
    rrGnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rrRv  = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    repeat (3) @(negedge clk);
    rstN = 1'b1;

    applyStimulus(0, 4'b00, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_outstanding", aOutst, 2'd0);
    checkOutput("rst_gnt", aGntO, 2'b00);
    checkOutput("rst_req", aDataReq, 1'b0);
    checkOutput("rst_rvalid", aRvalidO, 2'b00);
    checkOutput("rst_unexp", aUnexp, 1'b0);

    // Fixed priority: port 0 starves port 1 while it keeps requesting.
    applyStimulus(0, 4'b11, 1'b1, 1'b0, 1'b0);
    checkOutput("fix_gnt0", aGntO, 2'b01);
    checkOutput("fix_addr0", aAddrO, 32'hA000_0000);
    applyStimulus(0, 4'b11, 1'b1, 1'b1, 1'b0);
    checkOutput("fix_gnt1", aGntO, 2'b01);
    checkOutput("fix_rv1", aRvalidO, 2'b01);
    applyStimulus(0, 4'b11, 1'b1, 1'b1, 1'b0);
    checkOutput("fix_gnt2", aGntO, 2'b01);
    applyStimulus(0, 4'b10, 1'b1, 1'b1, 1'b0);
    checkOutput("fix_gnt_p1", aGntO, 2'b10);
    checkOutput("fix_we_p1", aDataWe, 1'b1);
    checkOutput("fix_rv_p0", aRvalidO, 2'b01);
    applyStimulus(0, 4'b00, 1'b0, 1'b1, 1'b0);
    checkOutput("fix_rv_p1", aRvalidO, 2'b10);
    applyStimulus(0, 4'b00, 1'b0, 1'b0, 1'b0);
    checkOutput("fix_drained", aOutst, 2'd0);

    // Full FIFO blocks the request even when a pop happens in the same cycle.
    applyStimulus(0, 4'b01, 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 4'b01, 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 4'b01, 1'b1, 1'b0, 1'b0);
    checkOutput("full_outst", aOutst, 2'd2);
    checkOutput("full_req", aDataReq, 1'b0);
    checkOutput("full_gnt", aGntO, 2'b00);
    applyStimulus(0, 4'b01, 1'b1, 1'b1, 1'b0);
    checkOutput("full_pop_req", aDataReq, 1'b0);
    checkOutput("full_pop_rv", aRvalidO, 2'b01);
    applyStimulus(0, 4'b01, 1'b0, 1'b0, 1'b0);
    checkOutput("after_pop_outst", aOutst, 2'd1);
    checkOutput("after_pop_req", aDataReq, 1'b1);
    applyStimulus(0, 4'b00, 1'b0, 1'b1, 1'b0);
    applyStimulus(0, 4'b00, 1'b0, 1'b0, 1'b0);
    checkOutput("full_drained", aOutst, 2'd0);

    // Responses follow issue order, each carrying its own error flag.
    applyStimulus(0, 4'b10, 1'b1, 1'b0, 1'b0);
    checkOutput("oos_gnt1", aGntO, 2'b10);
    applyStimulus(0, 4'b01, 1'b1, 1'b1, 1'b1);
    checkOutput("oos_gnt0", aGntO, 2'b01);
    checkOutput("oos_rv1", aRvalidO, 2'b10);
    checkOutput("oos_err1", aErrO, 2'b10);
    applyStimulus(0, 4'b00, 1'b0, 1'b1, 1'b0);
    checkOutput("oos_rv0", aRvalidO, 2'b01);
    checkOutput("oos_err0", aErrO, 2'b00);

    applyStimulus(0, 4'b00, 1'b0, 1'b1, 1'b0);
    checkOutput("unexp_pulse", aUnexp, 1'b1);
    checkOutput("unexp_rv", aRvalidO, 2'b00);
    applyStimulus(0, 4'b00, 1'b0, 1'b0, 1'b0);
    checkOutput("unexp_clear", aUnexp, 1'b0);

    // Round robin with every port requesting and a response one cycle behind.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 4'b1111, 1'b1, (i > 0), 1'b0);
      checkOutput($sformatf("rr_gnt%0d", i), bGntO, rrGnt[i]);
      checkOutput($sformatf("rr_rv%0d", i), bRvalidO, rrRv[i]);
    end
    applyStimulus(1, 4'b0000, 1'b0, 1'b1, 1'b0);
    checkOutput("rr_rv_last", bRvalidO, 4'b0001);
    applyStimulus(1, 4'b1000, 1'b1, 1'b0, 1'b0);
    checkOutput("rr_gnt3", bGntO, 4'b1000);
    applyStimulus(1, 4'b0000, 1'b0, 1'b1, 1'b0);
    checkOutput("rr_rv3", bRvalidO, 4'b1000);

    // Port 2 stalls; pointer now favours port 0, but the lock keeps port 2 on the bus.
    applyStimulus(1, 4'b0100, 1'b0, 1'b0, 1'b0);
    checkOutput("lock_addr1", bAddrO, 32'h1000_0200);
    checkOutput("lock_req1", bDataReq, 1'b1);
    applyStimulus(1, 4'b0101, 1'b0, 1'b0, 1'b0);
    checkOutput("lock_addr2", bAddrO, 32'h1000_0200);
    checkOutput("lock_we", bDataWe, 1'b1);
    checkOutput("lock_be", bBeO, 4'b0011);
    checkOutput("lock_wdata", bWdataO, 32'hCAFE_0002);
    checkOutput("lock_gnt_none", bGntO, 4'b0000);
    applyStimulus(1, 4'b0101, 1'b0, 1'b0, 1'b0);
    checkOutput("lock_addr3", bAddrO, 32'h1000_0200);
    applyStimulus(1, 4'b0101, 1'b1, 1'b0, 1'b0);
    checkOutput("lock_gnt", bGntO, 4'b0100);
    applyStimulus(1, 4'b0101, 1'b0, 1'b0, 1'b0);
    checkOutput("unlock_addr", bAddrO, 32'h1000_0000);
    applyStimulus(1, 4'b0000, 1'b0, 1'b1, 1'b0);
    checkOutput("lock_rv", bRvalidO, 4'b0100);
    checkOutput("rdata_bcast", bRdataO, 32'hDEAD_BEEF);

    // Asynchronous reset discards in-flight IDs.
    applyStimulus(0, 4'b01, 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 4'b01, 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 4'b00, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_rst_outst", aOutst, 2'd2);
    rstN = 1'b0;
    #1;
    checkOutput("async_rst_outst", aOutst, 2'd0);
    #2;
    rstN = 1'b1;
    applyStimulus(0, 4'b00, 1'b0, 1'b1, 1'b0);
    checkOutput("post_rst_unexp", aUnexp, 1'b1);
    checkOutput("post_rst_rv", aRvalidO, 2'b00);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
